// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage of the pipelined MIPS core. Owns the
//                fetch PC, requests instruction words over a req/ack
//                handshake and buffers returned words in a small in-order
//                queue presented to decode as {PC, inst, valid}. Handles
//                decode pause and branch/jump redirects, including redirects
//                that land while a memory request is outstanding.
//  Config      : IF_PREFETCH_EN - when defined the queue is two entries deep
//                and a new request may be issued while the head is paused;
//                when undefined the queue holds a single entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    // decode-stage control
    input  logic        i_IF_pause,
    input  logic        i_IF_brTaken,
    input  logic [31:0] i_IF_brTarget,
    input  logic        i_IF_jump,
    input  logic [25:0] i_IF_targetPC,
    input  logic [31:0] i_IF_decPC,
    // instruction memory
    output logic        o_IF_iMemReq,
    output logic [31:0] o_IF_iMemAddr,
    input  logic        i_IF_iMemAck,
    input  logic [31:0] i_IF_iMemRData,
    // to decode
    output logic        o_IF_valid,
    output logic [31:0] o_IF_PC,
    output logic [31:0] o_IF_inst
);

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    // IDLE: no request; REQ: live request; DRAIN: request abandoned by a
    // redirect, waiting for its ack so the handshake is not broken.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_next;
    logic [31:0]      req_addr;
    logic [31:0]      req_addr_next;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];

    logic             redirect;
    logic [3:0]       jump_region;
    logic [31:0]      jump_target;
    logic [31:0]      redirect_target;
    logic             head_valid;
    logic             ack_fire;
    logic             enq;
    logic             deq;

    // ------------------------------------------------------------------
    // Redirect decode: branch beats jump; jump keeps the 256 MB region of
    // the instruction after the jump.
    // ------------------------------------------------------------------
    assign redirect        = i_IF_brTaken | i_IF_jump;
    assign jump_region     = 4'((i_IF_decPC + 32'd4) >> 28);
    assign jump_target     = {jump_region, i_IF_targetPC, 2'b00};
    assign redirect_target = i_IF_brTaken ? i_IF_brTarget : jump_target;

    // ------------------------------------------------------------------
    // Queue control. Only a live request (REQ) can enqueue; data for an
    // abandoned request (DRAIN) or one acked during a redirect is dropped.
    // ------------------------------------------------------------------
    assign head_valid = (count != '0);
    assign ack_fire   = (state == ST_REQ) && i_IF_iMemAck;
    assign enq        = ack_fire && !redirect;
    assign deq        = head_valid && !i_IF_pause;
    assign wr_idx     = count - CNT_W'(deq);

    // Occupancy after this cycle; a redirect flushes regardless of pause.
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Fetch PC after this cycle: redirect target, else advance past an
    // accepted word (wraps naturally at 2^32).
    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = redirect_target;
        end else if (enq) begin
            fetch_pc_next = req_addr + 32'd4;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and request-address selection. A request is only
    // launched when a slot will be free, so a paused head never blocks
    // an ack.
    always_comb begin
        state_next    = state;
        req_addr_next = req_addr;
        case (state)
            ST_IDLE: begin
                if ((count_next < DEPTH_C) || redirect) begin
                    state_next    = ST_REQ;
                    req_addr_next = fetch_pc_next;
                end
            end
            ST_REQ: begin
                if (i_IF_iMemAck) begin
                    if (redirect || (count_next < DEPTH_C)) begin
                        state_next    = ST_REQ;
                        req_addr_next = fetch_pc_next;
                    end else begin
                        state_next    = ST_IDLE;
                    end
                end else if (redirect) begin
                    // keep the abandoned address on the bus until acked
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_IF_iMemAck) begin
                    state_next    = ST_REQ;
                    req_addr_next = fetch_pc_next;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request is held through both live and draining phases.
    always_comb begin
        o_IF_iMemReq  = (state == ST_REQ) || (state == ST_DRAIN);
        o_IF_iMemAddr = req_addr;
        o_IF_valid    = head_valid;
        o_IF_PC       = pc_q[0];
        o_IF_inst     = inst_q[0];
    end

    // Datapath registers: occupancy, fetch PC and outstanding address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            count    <= count_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
        end
    end

    // Shift queue: entry 0 is the head; a dequeue shifts down and an
    // enqueue lands just behind the surviving entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && (int'(wr_idx) == i)) begin
                    pc_q[i]   <= req_addr;
                    inst_q[i] <= i_IF_iMemRData;
                end else if (deq && (i < DEPTH - 1)) begin
                    pc_q[i]   <= pc_q[(i < DEPTH - 1) ? i + 1 : i];
                    inst_q[i] <= inst_q[(i < DEPTH - 1) ? i + 1 : i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A queue-based reference
//                model tracks the decode-visible entries and the outstanding
//                memory request; directed scenarios are followed by random
//                pause/redirect/ack traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pause = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jump = 1'b0;
    logic [25:0] target_pc = '0;
    logic [31:0] dec_pc = '0;
    logic        ack = 1'b0;
    wire  [31:0] rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [63:0] m_q [$];
    logic [31:0] m_fetch;
    logic [31:0] m_addr;
    logic        m_busy;
    logic        m_stale;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_IF_pause     (pause),
        .i_IF_brTaken   (br_taken),
        .i_IF_brTarget  (br_target),
        .i_IF_jump      (jump),
        .i_IF_targetPC  (target_pc),
        .i_IF_decPC     (dec_pc),
        .o_IF_iMemReq   (mem_req),
        .o_IF_iMemAddr  (mem_addr),
        .i_IF_iMemAck   (ack),
        .i_IF_iMemRData (rdata),
        .o_IF_valid     (valid),
        .o_IF_PC        (pc),
        .o_IF_inst      (inst)
    );

    // memory contents: a distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    assign rdata = mem_word(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch = 32'h0;
        m_addr  = 32'h0;
        m_busy  = 1'b0;
        m_stale = 1'b0;
    endtask

    // One clock of the reference behaviour, using the inputs held this cycle.
    task automatic model_step();
        logic        redir;
        logic        accepted;
        logic [31:0] nxt;
        logic [31:0] tgt;
        logic [63:0] dummy;
        redir    = br_taken | jump;
        nxt      = dec_pc + 32'd4;
        tgt      = br_taken ? br_target : {nxt[31:28], target_pc, 2'b00};
        accepted = m_busy && ack;
        if (m_q.size() != 0 && !pause) dummy = m_q.pop_front();
        if (accepted && !m_stale && !redir) begin
            m_q.push_back({m_addr, mem_word(m_addr)});
            m_fetch = m_addr + 32'd4;
        end
        if (redir) begin
            m_q.delete();
            m_fetch = tgt;
        end
        if (m_busy && !accepted) begin
            if (redir) m_stale = 1'b1;
        end else begin
            m_stale = 1'b0;
            if (m_q.size() < DEPTH || redir) begin
                m_busy = 1'b1;
                m_addr = m_fetch;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("req", 32'(mem_req), 32'(m_busy));
        if (m_busy) check("addr", mem_addr, m_addr);
        check("valid", 32'(valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("pc", pc, m_q[0][63:32]);
            check("inst", inst, m_q[0][31:0]);
        end
    endtask

    // Called at a falling edge: apply inputs, check outputs, advance a clock.
    task automatic run_cycle(input logic p, input logic b, input logic [31:0] bt,
                             input logic j, input logic [25:0] tp,
                             input logic [31:0] dp, input logic a);
        pause     = p;
        br_taken  = b;
        br_target = bt;
        jump      = j;
        target_pc = tp;
        dec_pc    = dp;
        ack       = a;
        compare_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic plain(input logic p, input logic a);
        run_cycle(p, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req), 32'h0);
        check({tag, "_addr"},  mem_addr,     32'h0);
        check({tag, "_valid"}, 32'(valid),   32'h0);
        check({tag, "_pc"},    pc,           32'h0);
        check({tag, "_inst"},  inst,         32'h0);
    endtask

    initial begin
        logic [31:0] held;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");

        // release reset; ack tied high, no pause
        rstn = 1'b1;
        repeat (12) plain(1'b0, 1'b1);

        // pause held 5 cycles with ack high: queue fills, request drops
        repeat (5) plain(1'b1, 1'b1);
        check("pause_req", 32'(mem_req), 32'h0);
        check("pause_valid", 32'(valid), 32'h1);
        repeat (6) plain(1'b0, 1'b1);

        // ack delayed 3 cycles
        repeat (3) plain(1'b0, 1'b0);
        repeat (3) plain(1'b0, 1'b1);

        // branch while a request is pending with no ack: drain then target
        repeat (3) plain(1'b0, 1'b0);
        check("drain_pre_req", 32'(mem_req), 32'h1);
        held = mem_addr;
        run_cycle(1'b0, 1'b1, 32'h0000_0400, 1'b0, 26'h0, 32'h0, 1'b0);
        check("drain_req", 32'(mem_req), 32'h1);
        check("drain_addr", mem_addr, held);
        check("drain_valid", 32'(valid), 32'h0);
        plain(1'b0, 1'b1);
        check("drain_tgt_addr", mem_addr, 32'h0000_0400);
        plain(1'b0, 1'b1);
        check("drain_tgt_pc", pc, 32'h0000_0400);
        check("drain_tgt_valid", 32'(valid), 32'h1);

        // jump, then jump with simultaneous branch
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h1000_0008, 1'b1);
        check("jump_addr", mem_addr, 32'h1000_0040);
        check("jump_valid", 32'(valid), 32'h0);
        run_cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 26'h10, 32'h1000_0008, 1'b1);
        check("br_prio_addr", mem_addr, 32'h0000_0200);
        repeat (3) plain(1'b0, 1'b1);

        // PC wrap at the top of the address space
        run_cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 26'h0, 32'h0, 1'b1);
        repeat (6) plain(1'b0, 1'b1);

        // reset while a request is outstanding, then a stray ack
        repeat (2) plain(1'b0, 1'b0);
        check("mid_pre_req", 32'(mem_req), 32'h1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        plain(1'b0, 1'b1);
        check("restart_addr", mem_addr, 32'h0000_0000);
        repeat (4) plain(1'b0, 1'b1);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            run_cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 11) == 0,
                      $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 11) == 0,
                      26'($urandom),
                      $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
